// File: rtl/packet_slot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : packet_slot_arbiter_pkg
// Brief    : Shared types, constants and round-robin pick helper.
// Revision : 1.0 - initial release
// ============================================================================
package packet_slot_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_t;

  localparam int SLOT_PIXELS = 32;

  // The helper works on a fixed 32-bit carrier so one function serves any group size.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  // One-hot pick of the first set bit at or after ptr, wrapping within n bits.
  function automatic logic [RR_MAX-1:0] rr_onehot_pick(
    input logic [RR_MAX-1:0] req,
    input int unsigned       ptr,
    input int unsigned       n
  );
    logic [RR_MAX-1:0]   pick;
    logic [RR_IDX_W-1:0] sel;
    int unsigned         idx;
    logic                found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      sel = idx[RR_IDX_W-1:0];
      if (!found && (k < n) && req[sel]) begin
        pick[sel] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/packet_slot_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : packet_slot_arbiter_if
// Brief    : Island announce, request and slot/grant signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface packet_slot_arbiter_if
  import packet_slot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 6
);
  logic               video_field_end;
  logic               island_start;
  logic [4:0]         island_slots;
  logic [NUM_REQ-1:0] req;

  logic               packet_enable;
  logic [4:0]         packet_pixel_counter;
  logic [NUM_REQ-1:0] grant;
  logic               null_slot;
  logic               island_active;
  logic               overrun;

  modport master (
    output video_field_end, island_start, island_slots, req,
    input  packet_enable, packet_pixel_counter, grant, null_slot, island_active, overrun
  );

  modport slave (
    input  video_field_end, island_start, island_slots, req,
    output packet_enable, packet_pixel_counter, grant, null_slot, island_active, overrun
  );
endinterface
`default_nettype wire

// File: rtl/packet_slot_arbiter_round_robin_select.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_select
// Brief    : Combinational rotate-and-priority-encode for the round-robin group.
// Revision : 1.0 - initial release
// ============================================================================
module round_robin_select
  import packet_slot_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  wire logic [N-1:0]     req,
  input  wire logic [PTR_W-1:0] ptr,
  output logic      [N-1:0]     pick,
  output logic                  any
);
  logic [RR_MAX-1:0] req_ext;
  logic [RR_MAX-1:0] pick_ext;
  logic              unused_pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick_ext       = rr_onehot_pick(req_ext, 32'(ptr), N);
  end

  assign pick        = pick_ext[N-1:0];
  assign any         = |req;
  assign unused_pick = ^pick_ext;

endmodule
`default_nettype wire

// File: rtl/packet_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : packet_slot_arbiter
// Brief    : HDMI data-island slot sequencer and per-slot packet source arbiter.
// Config   : define PACKET_SLOT_ARBITER_STARVATION_EN for starvation promotion.
// Revision : 1.0 - initial release
// ============================================================================
module packet_slot_arbiter
  import packet_slot_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 6,
  parameter int NUM_URGENT   = 2,
  parameter int MAX_SLOTS    = 18,
  parameter int STARVE_LIMIT = 8
) (
  input wire logic              clk_pixel,
  input wire logic              reset,
  packet_slot_arbiter_if.slave  bus
);
  localparam int         NUM_RR     = NUM_REQ - NUM_URGENT;
  localparam int         PTR_W      = (NUM_RR > 1) ? $clog2(NUM_RR) : 1;
  localparam logic [4:0] LAST_PIXEL = 5'(SLOT_PIXELS - 1);
  localparam logic [4:0] SLOT_CAP   = 5'(MAX_SLOTS);

  state_t             state_q, state_d;
  logic [4:0]         slots_left_q, slots_left_d;
  logic [4:0]         pix_q, pix_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               null_slot_q, null_slot_d;
  logic               packet_enable_q, packet_enable_d;
  logic               island_active_q, island_active_d;
  logic               overrun_q, overrun_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_URGENT-1:0] urgent_req, urgent_pick;
  logic [NUM_RR-1:0]     rr_req, rr_pick_vec, starved, starved_pick, rr_win;
  logic                  rr_any;
  logic [PTR_W-1:0]      rr_ptr_eff, rr_win_idx, rr_next_ptr;
  logic [NUM_REQ-1:0]    arb_grant;
  logic                  start_ok, slot_last_pix, arb_evt;

  assign urgent_req = bus.req[NUM_URGENT-1:0];
  assign rr_req     = bus.req[NUM_REQ-1:NUM_URGENT];
  // A field end on a boundary cycle must reach that boundary's arbitration.
  assign rr_ptr_eff = bus.video_field_end ? '0 : rr_ptr_q;

  assign start_ok      = (state_q == IDLE) && bus.island_start && (bus.island_slots != 5'd0);
  assign slot_last_pix = (state_q == SLOT) && (pix_q == LAST_PIXEL);
  assign arb_evt       = start_ok || (slot_last_pix && (slots_left_q != 5'd1));

  round_robin_select #(
    .N     (NUM_RR),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req  (rr_req),
    .ptr  (rr_ptr_eff),
    .pick (rr_pick_vec),
    .any  (rr_any)
  );

`ifdef PACKET_SLOT_ARBITER_STARVATION_EN
  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q   [NUM_RR];
  logic [CNT_W-1:0] starve_d   [NUM_RR];
  logic [CNT_W-1:0] starve_eff [NUM_RR];

  always_comb begin
    for (int i = 0; i < NUM_RR; i++) begin
      starve_eff[i] = bus.video_field_end ? '0 : starve_q[i];
      starved[i]    = rr_req[i] && (starve_eff[i] == CNT_MAX);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RR; i++) begin
      starve_d[i] = starve_eff[i];
      if (!rr_req[i]) begin
        starve_d[i] = '0;
      end else if (arb_evt) begin
        if (rr_win[i])                      starve_d[i] = '0;
        else if (starve_eff[i] != CNT_MAX)  starve_d[i] = starve_eff[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RR; i++) starve_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RR; i++) starve_q[i] <= starve_d[i];
    end
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign starved = '0;
`endif

  always_comb begin
    urgent_pick  = urgent_req & (-urgent_req);
    starved_pick = starved & (-starved);
    arb_grant    = '0;
    if (|starved)         arb_grant[NUM_REQ-1:NUM_URGENT] = starved_pick;
    else if (|urgent_req) arb_grant[NUM_URGENT-1:0]       = urgent_pick;
    else if (rr_any)      arb_grant[NUM_REQ-1:NUM_URGENT] = rr_pick_vec;
  end

  assign rr_win = arb_grant[NUM_REQ-1:NUM_URGENT];

  always_comb begin
    rr_win_idx = '0;
    for (int i = 0; i < NUM_RR; i++) begin
      if (rr_win[i]) rr_win_idx = PTR_W'(i);
    end
    rr_next_ptr = (rr_win_idx == PTR_W'(NUM_RR - 1)) ? '0 : rr_win_idx + PTR_W'(1);
  end

  always_comb begin
    state_d         = state_q;
    slots_left_d    = slots_left_q;
    pix_d           = pix_q;
    grant_d         = grant_q;
    null_slot_d     = null_slot_q;
    packet_enable_d = 1'b0;
    island_active_d = island_active_q;
    overrun_d       = overrun_q;
    rr_ptr_d        = rr_ptr_eff;
    if (arb_evt && (|rr_win)) rr_ptr_d = rr_next_ptr;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d         = SLOT;
          slots_left_d    = (bus.island_slots > SLOT_CAP) ? SLOT_CAP : bus.island_slots;
          pix_d           = 5'd0;
          packet_enable_d = 1'b1;
          island_active_d = 1'b1;
          grant_d         = arb_grant;
          null_slot_d     = ~(|arb_grant);
        end
      end
      SLOT: begin
        if (bus.island_start) overrun_d = 1'b1;
        if (pix_q == LAST_PIXEL) begin
          slots_left_d = slots_left_q - 5'd1;
          pix_d        = 5'd0;
          if (slots_left_q != 5'd1) begin
            packet_enable_d = 1'b1;
            grant_d         = arb_grant;
            null_slot_d     = ~(|arb_grant);
          end else begin
            state_d         = IDLE;
            island_active_d = 1'b0;
            grant_d         = '0;
            null_slot_d     = 1'b0;
          end
        end else begin
          pix_d = pix_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      slots_left_q    <= 5'd0;
      pix_q           <= 5'd0;
      grant_q         <= '0;
      null_slot_q     <= 1'b0;
      packet_enable_q <= 1'b0;
      island_active_q <= 1'b0;
      overrun_q       <= 1'b0;
      rr_ptr_q        <= '0;
    end else begin
      state_q         <= state_d;
      slots_left_q    <= slots_left_d;
      pix_q           <= pix_d;
      grant_q         <= grant_d;
      null_slot_q     <= null_slot_d;
      packet_enable_q <= packet_enable_d;
      island_active_q <= island_active_d;
      overrun_q       <= overrun_d;
      rr_ptr_q        <= rr_ptr_d;
    end
  end

  assign bus.packet_enable        = packet_enable_q;
  assign bus.packet_pixel_counter = pix_q;
  assign bus.grant                = grant_q;
  assign bus.null_slot            = null_slot_q;
  assign bus.island_active        = island_active_q;
  assign bus.overrun              = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_slot_arbiter
// Brief    : Scoreboard bench; a reference arbiter predicts each slot's grant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_slot_arbiter;
  localparam int NUM_REQ      = 6;
  localparam int NUM_URGENT   = 2;
  localparam int MAX_SLOTS    = 18;
  localparam int STARVE_LIMIT = 8;
  localparam int NUM_RR       = NUM_REQ - NUM_URGENT;

  logic clk_pixel = 1'b0;
  logic reset;

  packet_slot_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  packet_slot_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .NUM_URGENT   (NUM_URGENT),
    .MAX_SLOTS    (MAX_SLOTS),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int                 tests = 0;
  int                 fails = 0;
  int                 en_count;
  logic               ovr_exp;
  logic [NUM_REQ-1:0] exp_q[$];

  // Reference state: last round-robin winner and per-requester loss counts.
  int                 rr_last;
  int                 starve [NUM_REQ];
  logic [NUM_REQ-1:0] req_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_field_end();
    rr_last = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) starve[i] = 0;
  endfunction

  task automatic set_req(input logic [NUM_REQ-1:0] r);
    req_v   = r;
    bus.req = r;
    for (int i = 0; i < NUM_REQ; i++) if (!r[i]) starve[i] = 0;
  endtask

  function automatic logic [NUM_REQ-1:0] model_arb();
    int                 w;
    logic [NUM_REQ-1:0] g;
    w = -1;
    g = '0;
`ifdef PACKET_SLOT_ARBITER_STARVATION_EN
    for (int i = NUM_URGENT; i < NUM_REQ; i++)
      if (w < 0 && req_v[i] && starve[i] >= STARVE_LIMIT) w = i;
`endif
    for (int i = 0; i < NUM_URGENT; i++)
      if (w < 0 && req_v[i]) w = i;
    for (int k = 1; k <= NUM_RR; k++) begin
      int i;
      i = NUM_URGENT + ((rr_last - NUM_URGENT + k) % NUM_RR);
      if (w < 0 && req_v[i]) w = i;
    end
    if (w >= NUM_URGENT) rr_last = w;
    for (int i = NUM_URGENT; i < NUM_REQ; i++) begin
      if (i == w || !req_v[i])        starve[i] = 0;
      else if (starve[i] < STARVE_LIMIT) starve[i]++;
    end
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  // Monitor: every slot start is matched against the oldest prediction.
  initial begin
    logic [NUM_REQ-1:0] e;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (!reset && bus.packet_enable) begin
        en_count++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_enable: got enable with no predicted slot at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("grant", 32'(bus.grant), 32'(e));
          check("null_slot", 32'(bus.null_slot), 32'(e == '0));
          check("pix_at_enable", 32'(bus.packet_pixel_counter), 32'd0);
        end
      end
    end
  end

  task automatic run_island(input int slots, input logic [NUM_REQ-1:0] r0, input bit drop,
                            input int raise_pct, input bit fe_start, input int fe_slot,
                            input int ovr_slot, input int rst_slot);
    int                 n;
    logic [NUM_REQ-1:0] g, nr;
    n = (slots > MAX_SLOTS) ? MAX_SLOTS : slots;
    g = '0;
    @(negedge clk_pixel);
    if (fe_start) begin
      bus.video_field_end = 1'b1;
      model_field_end();
    end
    set_req(r0);
    bus.island_slots = 5'(slots);
    bus.island_start = 1'b1;
    en_count         = 0;
    if (n > 0) begin
      g = model_arb();
      exp_q.push_back(g);
    end
    @(posedge clk_pixel);
    #1;
    check("active_after_start", 32'(bus.island_active), 32'(n > 0));
    if (n == 0) begin
      check("no_enable_zero_slots", 32'(bus.packet_enable), 32'd0);
      @(negedge clk_pixel);
      bus.island_start    = 1'b0;
      bus.video_field_end = 1'b0;
      return;
    end
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < 32; p++) begin
        @(negedge clk_pixel);
        bus.island_start    = 1'b0;
        bus.video_field_end = 1'b0;
        if (p == 10 && k == rst_slot) begin
          #2 reset = 1'b1;
          #1;
          check("rst_grant", 32'(bus.grant), 32'd0);
          check("rst_enable", 32'(bus.packet_enable), 32'd0);
          check("rst_pix", 32'(bus.packet_pixel_counter), 32'd0);
          check("rst_active", 32'(bus.island_active), 32'd0);
          check("rst_null", 32'(bus.null_slot), 32'd0);
          check("rst_overrun", 32'(bus.overrun), 32'd0);
          exp_q.delete();
          model_field_end();
          set_req('0);
          ovr_exp = 1'b0;
          @(negedge clk_pixel);
          reset = 1'b0;
          return;
        end
        if (p == 15) begin
          if (k == fe_slot) begin
            bus.video_field_end = 1'b1;
            model_field_end();
          end
          if (k == ovr_slot) begin
            bus.island_start = 1'b1;
            bus.island_slots = 5'($urandom_range(1, 31));
            ovr_exp          = 1'b1;
          end
          if (k < n - 1) begin
            nr = req_v;
            if (drop) nr = nr & ~g;
            for (int i = 0; i < NUM_REQ; i++)
              if ($urandom_range(0, 99) < raise_pct) nr[i] = 1'b1;
            set_req(nr);
            g = model_arb();
            exp_q.push_back(g);
          end
        end
        if (p == 31) check("pix_end", 32'(bus.packet_pixel_counter), 32'd31);
      end
    end
    check("active_last_pix", 32'(bus.island_active), 32'd1);
    @(posedge clk_pixel);
    #1;
    check("active_falls", 32'(bus.island_active), 32'd0);
    check("slot_count", 32'(en_count), 32'(n));
    check("overrun", 32'(bus.overrun), 32'(ovr_exp));
  endtask

  initial begin
    bus.req             = '0;
    bus.island_start    = 1'b0;
    bus.island_slots    = 5'd0;
    bus.video_field_end = 1'b0;
    reset               = 1'b1;
    req_v               = '0;
    ovr_exp             = 1'b0;
    en_count            = 0;
    model_field_end();
    repeat (3) @(negedge clk_pixel);
    check("reset_grant", 32'(bus.grant), 32'd0);
    check("reset_null", 32'(bus.null_slot), 32'd0);
    check("reset_enable", 32'(bus.packet_enable), 32'd0);
    check("reset_pix", 32'(bus.packet_pixel_counter), 32'd0);
    check("reset_active", 32'(bus.island_active), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b0;

    run_island(3, 6'b000000, 1'b1, 0, 1'b0, -1, -1, -1);
    run_island(2, 6'b000011, 1'b1, 0, 1'b0, -1, -1, -1);
    run_island(8, 6'b111100, 1'b0, 0, 1'b1, -1, -1, -1);
    run_island(10, 6'b000101, 1'b0, 0, 1'b1, -1, -1, -1);
    run_island(0, 6'b000001, 1'b1, 0, 1'b0, -1, -1, -1);
    run_island(25, 6'b110010, 1'b1, 30, 1'b0, 5, 3, -1);
    run_island(4, 6'b111111, 1'b1, 20, 1'b0, -1, -1, 1);
    run_island(3, 6'b001100, 1'b1, 0, 1'b0, -1, -1, -1);

    for (int it = 0; it < 20; it++) begin
      int s;
      s = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 5));
      run_island(s, NUM_REQ'($urandom), 1'b1, 25, ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 4)), -1, -1);
      repeat ($urandom_range(1, 4)) @(negedge clk_pixel);
    end

    repeat (40) @(negedge clk_pixel);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/packet_slot_arbiter.md
# packet_slot_arbiter

Sequences HDMI data-island packet slots and shares them among packet sources. These sources are ACR, audio sample and InfoFrame generators. For each island the block issues one `packet_enable` per 32-pixel slot, drives the slot pixel counter and selects one requester per slot. It sits between the video timing generator, which announces islands, and the packet mux and encoder.

## Interface
Parameters:
- `NUM_REQ`, 6: number of requesters; index 0 is the highest-priority urgent requester.
- `NUM_URGENT`, 2: indices `0..NUM_URGENT-1` use strict fixed priority; the rest use round-robin.
- `MAX_SLOTS`, 18: cap on packets per island.
- `STARVE_LIMIT`, 8: number of lost slots before a round-robin requester is promoted.

Ports:
- `clk_pixel` in 1: pixel clock, the only clock.
- `reset` in 1: asynchronous, active-high.
- `video_field_end` in 1: single-cycle pulse at the end of each field.
- `island_start` in 1: single-cycle pulse; an island begins.
- `island_slots` in 5: number of slots in the announced island; sampled on `island_start`.
- `req` in `NUM_REQ`: level requests; a request is held until granted.
- `packet_enable` out 1: pulse on pixel 0 of each slot.
- `packet_pixel_counter` out 5: 0..31 within the current slot.
- `grant` out `NUM_REQ`: one-hot; held for the whole slot; all-zero means a null packet.
- `null_slot` out 1: high for the whole slot when no request won.
- `island_active` out 1: high while slots are being emitted.
- `overrun` out 1: sticky flag; `island_start` arrived while an island was active.

## Operation
- States: `IDLE`, `SLOT`.
- In `IDLE`, on `island_start` with `island_slots` ≠ 0:
  - load `slots_left` = min(`island_slots`, `MAX_SLOTS`);
  - arbitrate;
  - go to `SLOT`.
- In `IDLE`, `island_slots` = 0 leaves the block in `IDLE`.
- In `SLOT`, the pixel counter increments each cycle.
- At count 31:
  - decrement `slots_left`;
  - if the result is non-zero, re-arbitrate, wrap the counter to 0 and pulse `packet_enable`, with no gap between slots;
  - otherwise go to `IDLE`.
- Arbitration order, first match wins:
  1. Starved round-robin requesters: lowest index first, when starvation is enabled.
  2. Urgent requesters: lowest index first.
  3. Round-robin requesters: search starts at the index after the last round-robin grant, with wrap within `NUM_URGENT..NUM_REQ-1`.
- No request pending → `grant` = 0 and `null_slot` = 1.
- Grants are evaluated on `req` sampled in the arbitration cycle. A requester sees its `grant` bit and must drop `req` before the next slot boundary to avoid a second grant.
- The round-robin pointer updates only when a round-robin index wins, including a starved winner.
- On `video_field_end`:
  - the round-robin pointer resets to `NUM_URGENT`;
  - starvation counters clear;
  - the island in progress is not aborted.
- `island_start` while in `SLOT`: ignored and sets `overrun`. Only `reset` clears `overrun`.

## Timing
- All outputs are registered.
- `island_start` at cycle t → `island_active`, `packet_enable`, `grant` and `packet_pixel_counter` = 0 at t+1.
- Slot k starts at cycle t+1+32k. `island_active` falls at t+1+32·N, where N is the loaded slot count.
- Reset values:
  - state `IDLE`;
  - `grant` = 0, `null_slot` = 0;
  - `packet_enable` = 0, `packet_pixel_counter` = 0;
  - `island_active` = 0, `overrun` = 0;
  - round-robin pointer = `NUM_URGENT`, starvation counters = 0.
- Reset asserted mid-slot returns the block immediately (asynchronously) to reset values. The partial packet is dropped.
- `video_field_end` coincident with a slot boundary: the pointer reset takes effect before that boundary's arbitration.
- `video_field_end` coincident with `island_start`: both are honoured.
- Starvation counters are `$clog2(STARVE_LIMIT+1)` bits wide and saturate.
  - A counter increments at each slot boundary where its requester is requesting and loses.
  - A counter clears when its requester is granted or drops `req`.
  - The requester is starved when its counter = `STARVE_LIMIT`.

## Configuration
- `PACKET_SLOT_ARBITER_STARVATION_EN` defined: starvation counters and promotion are present.
- Macro undefined: counters are not built, and arbitration is strict urgent priority followed by round-robin.

## Structure
- Package `packet_slot_arbiter_pkg`:
  - state enum;
  - `SLOT_PIXELS` = 32;
  - function computing the one-hot round-robin pick from a request vector and a pointer.
- Sub-module `round_robin_select`: combinational rotate-and-priority-encode used for the round-robin group.

## Test plan
- `island_slots` = 3, no `req` → 3 `packet_enable` pulses at t+1, t+33, t+65; `null_slot` = 1 throughout; `island_active` falls at t+97.
- `req` = 6'b000011 held, 2 slots → `grant` = 000001 in both slots; with `req[0]` dropped after slot 0, slot 1 gets `grant` = 000010.
- `req[5:2]` all held, 8 slots → grants cycle 2,3,4,5,2,3,4,5.
- `req[0]` and `req[2]` held, with the macro defined and `STARVE_LIMIT` = 8 → slot 8 grants index 2; with the macro undefined, index 0 wins all slots.
- `island_slots` = 25 → exactly 18 slots are emitted; a second `island_start` mid-island sets `overrun` = 1 and the slot count is unchanged.
- `reset` pulsed at pixel 10 of slot 1 → outputs return to reset values in the same cycle; the next `island_start` behaves normally.
